count_sequencer: RTL
====================

# count_sequencer

Control-side companion of the 8-bit loadable up-counter (`clr`, `clk`, `l`, `s_s`, `c`, `d`). It accepts a command (start value, terminal value) over a valid/ready handshake and drives the counter's load, data and start/stop inputs. It watches the counter's count output and stops it exactly on the terminal value, then pulses `done`. It replaces hand-sequenced `l`/`s_s` stimulus with a reusable run-to-value controller.

## Interface
- `WIDTH`, 8: counter/data width.
- `TIMEOUT_CYCLES`, 300: maximum RUN cycles before abort (used only with `COUNT_SEQUENCER_TIMEOUT_EN`).

- `clk` in 1: clock; all state changes on the rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE; a transfer occurs when `cmd_valid && cmd_ready` at a clock edge.
- `cmd_start` in WIDTH: value to load into the counter.
- `cmd_term` in WIDTH: value at which counting must stop.
- `c` in WIDTH: counter's current count.
- `l` out 1: counter load strobe (registered).
- `s_s` out 1: counter start/stop, 1 = count (registered).
- `d` out WIDTH: counter load data (registered).
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; 1 = aborted by timeout.

## Operation
- Counter contract: synchronous; `l` has priority and loads `d`; otherwise `s_s=1` adds 1 modulo 2^WIDTH; otherwise the count holds.
- States:
  - IDLE: `l=0`, `s_s=0`. On a handshake, latch start/term and go to LOAD.
  - LOAD: `l=1`, `d=start` for exactly one cycle. Next state is DONE if start==term, else RUN.
  - RUN: `s_s=1`. When `c == term-1` (mod 2^WIDTH), go to DONE. The counter's final increment lands it on term.
  - DONE: `s_s=0`, `done=1` for one cycle. Return to IDLE.
- Counting length N = (term − start) mod 2^WIDTH. Wrap-around is legal (0xF0→0x05 gives N=21).
- `d` retains the last start value outside LOAD.
- `cmd_valid` while busy is ignored, not queued. The command fields are sampled only at the handshake edge.
- All outputs are registered except `cmd_ready` and `busy`, which decode the state.
- Reset (any time, including mid-RUN): state=IDLE, `l=0`, `s_s=0`, `d=0`, `done=0`, `err=0`. This gives `cmd_ready=1` and `busy=0`. The counter is left holding whatever it reached; no done pulse is produced.

## Timing
- Handshake edge at cycle T.
- T+1: `l=1`, `d=start`. The counter reads start from T+2.
- N>0: `s_s=1` for exactly N cycles, T+2 … T+1+N. `s_s` falls at T+2+N, with `c=term`.
- `done` is high in cycle T+2+N for every N, including N=0. For N=0, `s_s` never asserts.
- `cmd_ready` is high again at T+3+N. Earliest next handshake is that edge.
- Back-to-back command throughput: one command per N+3 cycles.

## Configuration
- `COUNT_SEQUENCER_TIMEOUT_EN` defined:
  - A RUN-cycle counter starts at 0 on RUN entry.
  - If it reaches `TIMEOUT_CYCLES` before the terminal match, go to DONE with `s_s=0`, `done=1`, `err=1`.
  - A match on the same cycle as the timeout wins: `err=0`.
- Macro undefined:
  - No watchdog logic; RUN lasts until the match (unbounded if `c` never tracks).
  - `err` is tied 0.
  - The `TIMEOUT_CYCLES` parameter is ignored.

## Test plan
- Reset: `clr` pulsed for 50 ns at 100 ns. During and after reset: `cmd_ready=1`, `l=0`, `s_s=0`, `d=0x00`, `done=0`, `err=0`.
- Wrap run: start=0xF0, term=0x05, with the real counter attached.
  - `l` high in T+1 with `d=0xF0`.
  - `s_s` high 21 cycles.
  - `done` at T+23 with `c=0x05`, `err=0`.
  - `c` holds 0x05 afterwards.
- Zero-length run: start=term=0x33. `l` pulse only, `s_s` never high, `done` at T+2, `c=0x33`.
- Busy rejection: `cmd_valid` held high during a run with start=0x00, term=0x10.
  - `cmd_ready=0` throughout; the second command is accepted only at T+19.
  - The second command starts from its own fields, not from values present while busy.
- Reset mid-RUN: `clr` asserted when `c=0x08` of a 0x00→0x20 run.
  - `s_s` drops asynchronously and no `done` pulse occurs.
  - `c` holds 0x08 (counter not cleared by the sequencer), then the next command executes normally.
- Timeout (macro defined, `TIMEOUT_CYCLES=16`): `c` stubbed constant 0x00, start=0x00, term=0x80.
  - `s_s` high 16 cycles, then `done=1`, `err=1` at T+18.
  - Macro undefined: `s_s` stays high, and `done` never asserts within 500 cycles.

Source files
------------

// File: rtl/count_sequencer.sv
// Run-to-value controller for an 8-bit loadable up-counter: load start, count, stop on term.
// Optional watchdog abort enabled by defining COUNT_SEQUENCER_TIMEOUT_EN.
module count_sequencer #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 300
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_term,
    input  logic [WIDTH-1:0] c,
    output logic             l,
    output logic             s_s,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             l_q, l_d;
    logic             s_s_q, s_s_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             timeout;
    logic [WIDTH-1:0] term_m1;

    // Stop one count early: the counter's last increment lands on term.
    assign term_m1 = term_q - {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef COUNT_SEQUENCER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] run_cnt_q, run_cnt_d;

    always_comb begin
        run_cnt_d = '0;
        if (state_q == S_RUN) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == S_RUN) &&
                     (run_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        term_d  = term_q;
        d_d     = d_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_LOAD;
                    start_d = cmd_start;
                    term_d  = cmd_term;
                    d_d     = cmd_start;
                end
            end
            S_LOAD: begin
                state_d = (start_q == term_q) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (c == term_m1) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered outputs follow the state being entered.
        l_d    = (state_d == S_LOAD);
        s_s_d  = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            start_q <= '0;
            term_q  <= '0;
            d_q     <= '0;
            l_q     <= 1'b0;
            s_s_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            term_q  <= term_d;
            d_q     <= d_d;
            l_q     <= l_d;
            s_s_q   <= s_s_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign l         = l_q;
    assign s_s       = s_s_q;
    assign d         = d_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
